// File: rtl/decrypt_run_ctrl.sv
// decrypt_run_ctrl: on a go pulse, runs the decrypt core NUM_RUNS times,
// timing each run and capturing its result word and timeout flag.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   go                1-cycle session start (ignored while busy)
//   busy, done        session in progress / 1-cycle completion pulse
//   core_start        1-cycle start pulse to the core
//   core_finish       core finish level (rising edge ends a run)
//   core_data         core result, sampled on the finish edge
//   rd_idx            per-run result select
//   rd_lat/rd_data/rd_tout  latency, result, timeout of run rd_idx
//   lat_min/lat_max/lat_sum session latency statistics
//
// Build option: define DECRYPT_RUN_STATS_EN to enable the statistics
// registers; otherwise lat_min/lat_max/lat_sum are tied to zero.

module decrypt_run_ctrl #(
  parameter int DATA_W   = 1,
  parameter int NUM_RUNS = 4,
  parameter int CYC_W    = 24,
  parameter int TIMEOUT  = 2**20,
  parameter int GAP_CYC  = 2,
  localparam int IDX_W   = (NUM_RUNS > 1) ? $clog2(NUM_RUNS) : 1,
  localparam int SUM_W   = CYC_W + $clog2(NUM_RUNS) + 1,
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              core_start,
  input  logic              core_finish,
  input  logic [DATA_W-1:0] core_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [CYC_W-1:0]  rd_lat,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_tout,
  output logic [CYC_W-1:0]  lat_min,
  output logic [CYC_W-1:0]  lat_max,
  output logic [SUM_W-1:0]  lat_sum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]  run_q;
  logic [CYC_W-1:0]  cnt_q;
  logic [CYC_W-1:0]  cnt_inc;
  logic [GAP_W-1:0]  gap_q;
  logic              finish_q;

  logic [CYC_W-1:0]  lat_q  [NUM_RUNS];
  logic [DATA_W-1:0] data_q [NUM_RUNS];
  logic              tout_q [NUM_RUNS];

  logic fin_rise;
  logic tmo;
  logic rec;
  logic last_run;
  logic gap_end;
  logic sess_go;

  assign cnt_inc  = cnt_q + 1'b1;
  // Only a fresh 0->1 transition ends a run; a level left high
  // by the previous run is not a finish.
  assign fin_rise = core_finish & ~finish_q;
  assign tmo      = (cnt_inc == CYC_W'(TIMEOUT));
  assign rec      = (state_q == S_WAIT) & (fin_rise | tmo);
  assign last_run = (run_q == IDX_W'(NUM_RUNS - 1));
  assign gap_end  = (gap_q == GAP_W'(GAP_CYC - 1));
  assign sess_go  = (state_q == S_IDLE) & go;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_START;
      S_START: begin
        core_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT:  if (rec) state_d = last_run ? S_DONE : S_GAP;
      S_GAP:   if (gap_end) state_d = S_START;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      run_q    <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      finish_q <= 1'b0;
      for (int i = 0; i < NUM_RUNS; i++) begin
        lat_q[i]  <= '0;
        data_q[i] <= '0;
        tout_q[i] <= 1'b0;
      end
    end else begin
      finish_q <= core_finish;
      if (sess_go) begin
        busy  <= 1'b1;
        run_q <= '0;
        for (int i = 0; i < NUM_RUNS; i++) begin
          lat_q[i]  <= '0;
          data_q[i] <= '0;
          tout_q[i] <= 1'b0;
        end
      end
      if (state_q == S_DONE) busy <= 1'b0;
      if (state_q == S_START) begin
        cnt_q <= '0;
        gap_q <= '0;
      end
      if (state_q == S_WAIT) cnt_q <= cnt_inc;
      // On a timeout cnt_inc equals TIMEOUT, so one latency path
      // covers edge, timeout and the tie between them.
      if (rec) begin
        lat_q[run_q]  <= cnt_inc;
        data_q[run_q] <= fin_rise ? core_data : '0;
        tout_q[run_q] <= ~fin_rise;
      end
      if (state_q == S_GAP) begin
        gap_q <= gap_q + 1'b1;
        if (gap_end) run_q <= run_q + 1'b1;
      end
    end
  end

  always_comb begin
    rd_lat  = '0;
    rd_data = '0;
    rd_tout = 1'b0;
    if (32'(rd_idx) < NUM_RUNS) begin
      rd_lat  = lat_q[rd_idx];
      rd_data = data_q[rd_idx];
      rd_tout = tout_q[rd_idx];
    end
  end

`ifdef DECRYPT_RUN_STATS_EN
  logic [CYC_W-1:0] min_q;
  logic [CYC_W-1:0] max_q;
  logic [SUM_W-1:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
      sum_q <= '0;
    end else if (sess_go) begin
      min_q <= '1;
      max_q <= '0;
      sum_q <= '0;
    end else if (rec) begin
      if (cnt_inc < min_q) min_q <= cnt_inc;
      if (cnt_inc > max_q) max_q <= cnt_inc;
      sum_q <= sum_q + SUM_W'(cnt_inc);
    end
  end

  assign lat_min = min_q;
  assign lat_max = max_q;
  assign lat_sum = sum_q;
`else
  assign lat_min = '0;
  assign lat_max = '0;
  assign lat_sum = '0;
`endif

endmodule

// File: tb/tb_decrypt_run_ctrl.sv
// tb_decrypt_run_ctrl: directed sessions against a behavioural core
// model; per-run expectations are queued at stimulus time.

module tb_decrypt_run_ctrl;

  localparam int DATA_W   = 1;
  localparam int NUM_RUNS = 4;
  localparam int CYC_W    = 24;
  localparam int TIMEOUT  = 64;
  localparam int GAP_CYC  = 2;
  localparam int IDX_W    = 2;
  localparam int SUM_W    = CYC_W + 2 + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              go;
  logic              busy;
  logic              done;
  logic              core_start;
  logic              core_finish = 1'b0;
  logic [DATA_W-1:0] core_data = '0;
  logic [IDX_W-1:0]  rd_idx;
  logic [CYC_W-1:0]  rd_lat;
  logic [DATA_W-1:0] rd_data;
  logic              rd_tout;
  logic [CYC_W-1:0]  lat_min;
  logic [CYC_W-1:0]  lat_max;
  logic [SUM_W-1:0]  lat_sum;

  always #5 clk = ~clk;

  decrypt_run_ctrl #(
    .DATA_W   (DATA_W),
    .NUM_RUNS (NUM_RUNS),
    .CYC_W    (CYC_W),
    .TIMEOUT  (TIMEOUT),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .busy        (busy),
    .done        (done),
    .core_start  (core_start),
    .core_finish (core_finish),
    .core_data   (core_data),
    .rd_idx      (rd_idx),
    .rd_lat      (rd_lat),
    .rd_data     (rd_data),
    .rd_tout     (rd_tout),
    .lat_min     (lat_min),
    .lat_max     (lat_max),
    .lat_sum     (lat_sum)
  );

  typedef struct packed {
    logic [CYC_W-1:0]  lat;
    logic [DATA_W-1:0] dat;
    logic              tout;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, want);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // core model: finish rises plan_lat cycles after the start cycle
  // (0 = never); pulse mode drops it a cycle later, hold mode keeps
  // it high until the second cycle after the next start.
  int   plan_lat [NUM_RUNS];
  logic plan_dat [NUM_RUNS];
  bit   plan_hold = 1'b0;
  int   mrun = 0;
  int   rise_at = -1;
  int   fall_at = -1;
  logic cur_dat = 1'b0;
  int   n_starts = 0;
  int   n_done = 0;
  int   start_times[$];

  always @(negedge clk) begin
    if (rst) begin
      core_finish = 1'b0;
      core_data   = '0;
      rise_at     = -1;
      fall_at     = -1;
    end else begin
      if (cyc == fall_at) core_finish = 1'b0;
      if (cyc == rise_at) begin
        core_finish = 1'b1;
        core_data   = cur_dat;
        if (!plan_hold) fall_at = cyc + 1;
      end
      if (core_start) begin
        n_starts++;
        start_times.push_back(cyc);
        if (mrun < NUM_RUNS) begin
          cur_dat = plan_dat[mrun];
          rise_at = (plan_lat[mrun] == 0) ? -1 : cyc + plan_lat[mrun];
        end
        fall_at = plan_hold ? cyc + 2 : cyc + 1;
        mrun++;
      end
      if (done) n_done++;
    end
  end

  function automatic exp_t expect_run(input int l, input logic d);
    exp_t e;
    if (l == 0 || l > TIMEOUT) begin
      e.lat  = CYC_W'(TIMEOUT);
      e.dat  = '0;
      e.tout = 1'b1;
    end else begin
      e.lat  = CYC_W'(l);
      e.dat  = d;
      e.tout = 1'b0;
    end
    return e;
  endfunction

  task automatic session(input int l0, input int l1, input int l2,
                         input int l3, input logic [3:0] d,
                         input bit hold, input bit chk_gap,
                         input int go_again);
    int   k;
    exp_t e;
    longint smin, smax, ssum;
    plan_lat[0] = l0;
    plan_lat[1] = l1;
    plan_lat[2] = l2;
    plan_lat[3] = l3;
    for (int i = 0; i < NUM_RUNS; i++) plan_dat[i] = d[i];
    plan_hold = hold;
    mrun      = 0;
    n_starts  = 0;
    n_done    = 0;
    start_times.delete();
    smin = (64'd1 << CYC_W) - 1;
    smax = 0;
    ssum = 0;
    for (int i = 0; i < NUM_RUNS; i++) begin
      e = expect_run(plan_lat[i], plan_dat[i]);
      sb.push_back(e);
      if (e.lat < smin) smin = e.lat;
      if (e.lat > smax) smax = e.lat;
      ssum += e.lat;
    end
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    #1;
    chk("busy_set", busy, 1);
    k = 0;
    while (n_done == 0 && k < 3000) begin
      @(negedge clk);
      #1;
      k++;
      go = (go_again > 0 && k == go_again);
    end
    go = 1'b0;
    chk("done_seen", n_done != 0, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("done_once", n_done, 1);
    chk("starts", n_starts, NUM_RUNS);
    chk("busy_clr", busy, 0);
    if (chk_gap)
      for (int i = 1; i < start_times.size(); i++)
        chk($sformatf("start_gap%0d", i),
            start_times[i] - start_times[i-1], l0 + GAP_CYC + 1);
    for (int i = 0; i < NUM_RUNS; i++) begin
      e = sb.pop_front();
      rd_idx = IDX_W'(i);
      #1;
      chk($sformatf("rd_lat%0d", i), rd_lat, e.lat);
      chk($sformatf("rd_data%0d", i), rd_data, e.dat);
      chk($sformatf("rd_tout%0d", i), rd_tout, e.tout);
    end
`ifdef DECRYPT_RUN_STATS_EN
    chk("lat_min", lat_min, smin);
    chk("lat_max", lat_max, smax);
    chk("lat_sum", lat_sum, ssum);
`else
    chk("lat_min", lat_min, 0);
    chk("lat_max", lat_max, 0);
    chk("lat_sum", lat_sum, 0);
`endif
  endtask

  task automatic zero_checks(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_start"}, core_start, 0);
    for (int i = 0; i < NUM_RUNS; i++) begin
      rd_idx = IDX_W'(i);
      #1;
      chk($sformatf("%s_rd_lat%0d", pfx, i), rd_lat, 0);
      chk($sformatf("%s_rd_data%0d", pfx, i), rd_data, 0);
      chk($sformatf("%s_rd_tout%0d", pfx, i), rd_tout, 0);
    end
    chk({pfx, "_min"}, lat_min, 0);
    chk({pfx, "_max"}, lat_max, 0);
    chk({pfx, "_sum"}, lat_sum, 0);
  endtask

  initial begin
    int k;
    rst    = 1'b1;
    go     = 1'b0;
    rd_idx = '0;
    repeat (2) @(negedge clk);
    #1;
    zero_checks("reset");
    rst = 1'b0;

    // fixed 37-cycle core
    session(37, 37, 37, 37, 4'b1010, 1'b0, 1'b1, 0);
    // mixed latencies; stats 3/12/29 with the option enabled
    session(5, 9, 3, 12, 4'b1101, 1'b0, 1'b0, 0);
    // run 1 never finishes; run 3 finishes exactly at TIMEOUT
    session(5, 0, 7, TIMEOUT, 4'b1111, 1'b0, 1'b0, 0);
    // finish level held high across gaps
    session(6, 6, 6, 6, 4'b0101, 1'b1, 1'b0, 0);
    // extra go while busy; run 1 finishes one cycle after start
    session(8, 1, 8, 8, 4'b0011, 1'b0, 1'b0, 10);

    // reset in the middle of run 2
    for (int i = 0; i < NUM_RUNS; i++) begin
      plan_lat[i] = 10;
      plan_dat[i] = 1'b1;
    end
    plan_hold = 1'b0;
    mrun      = 0;
    n_starts  = 0;
    n_done    = 0;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    k = 0;
    while (n_starts < 3 && k < 500) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("rst_run2_reached", n_starts, 3);
    repeat (4) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    zero_checks("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    chk("midrst_no_done", n_done, 0);
    chk("midrst_no_start", n_starts, 3);

    session(4, 4, 4, 4, 4'b1001, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
